if_stage_hbit: RTL and testbench

IF_STAGE_HBIT -- requirements
Module: if_stage_hbit

---
 rtl/if_stage_hbit.sv | 101 ++++++++++
 tb/tb_if_stage_hbit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_hbit.sv
// Instruction-fetch stage with an 8-entry one-bit (hbit) branch history table.
// The next PC is chosen in the same cycle as the lookup; redirects take effect one edge later.
module if_stage_hbit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_IF,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        hbit_upd_valid,
  input  logic [15:0] hbit_upd_pc,
  input  logic [15:0] hbit_upd_target,
  input  logic        hbit_upd_taken,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] out_IW,
  output logic [15:0] out_pc,
  output logic        out_valid,
  output logic        out_BPR
);

  logic [15:0]      pc_q, pc_d;
  logic             started_q, started_d;
  logic [7:0]       ent_valid_q, ent_valid_d;
  logic [7:0]       ent_hbit_q, ent_hbit_d;
  logic [7:0][12:0] ent_tag_q, ent_tag_d;
  logic [7:0][15:0] ent_tgt_q, ent_tgt_d;

  logic [2:0]       idx_s;
  logic             hit_s;
  logic             predict_taken_s;
  logic             fetch_valid_s;

  assign idx_s = pc_q[2:0];

  // Table lookup reads the registered contents, so a same-cycle update is not seen yet.
  always_comb begin
    hit_s           = ent_valid_q[idx_s] && (ent_tag_q[idx_s] == pc_q[15:3]);
    predict_taken_s = hit_s && ent_hbit_q[idx_s];
  end

  always_comb begin
    fetch_valid_s = resetn && started_q && !redirect_valid;
    imem_addr     = pc_q;
    out_pc        = resetn ? pc_q : 16'h0000;
    out_valid     = fetch_valid_s;
    if (fetch_valid_s) begin
      out_IW  = imem_data;
      out_BPR = predict_taken_s;
    end else begin
      out_IW  = 16'hfffe;
      out_BPR = 1'b0;
    end
  end

  // Reset drops any redirect or table update presented in the same cycle.
  always_comb begin
    pc_d        = pc_q;
    started_d   = started_q;
    ent_valid_d = ent_valid_q;
    ent_hbit_d  = ent_hbit_q;
    ent_tag_d   = ent_tag_q;
    ent_tgt_d   = ent_tgt_q;
    if (!resetn) begin
      pc_d        = 16'h0000;
      started_d   = 1'b0;
      ent_valid_d = 8'h00;
      ent_hbit_d  = 8'h00;
      ent_tag_d   = {8{13'h0000}};
      ent_tgt_d   = {8{16'h0000}};
    end else begin
      started_d = 1'b1;
      if (redirect_valid) begin
        pc_d = redirect_pc;
      end else if (stall_IF) begin
        pc_d = pc_q;
      end else if (predict_taken_s) begin
        pc_d = ent_tgt_q[idx_s];
      end else begin
        pc_d = pc_q + 16'h0001;
      end
      if (hbit_upd_valid) begin
        ent_valid_d[hbit_upd_pc[2:0]] = 1'b1;
        ent_tag_d[hbit_upd_pc[2:0]]   = hbit_upd_pc[15:3];
        ent_hbit_d[hbit_upd_pc[2:0]]  = hbit_upd_taken;
        ent_tgt_d[hbit_upd_pc[2:0]]   = hbit_upd_target;
      end else begin
        ent_valid_d = ent_valid_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    pc_q        <= pc_d;
    started_q   <= started_d;
    ent_valid_q <= ent_valid_d;
    ent_hbit_q  <= ent_hbit_d;
    ent_tag_q   <= ent_tag_d;
    ent_tgt_q   <= ent_tgt_d;
  end

endmodule

// File: tb/tb_if_stage_hbit.sv
// Self-checking bench for if_stage_hbit: directed scenarios plus a random run
// compared against a table-of-structs reference model.
module tb_if_stage_hbit;

  logic        clk;
  logic        resetn;
  logic        stall_IF;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        hbit_upd_valid;
  logic [15:0] hbit_upd_pc;
  logic [15:0] hbit_upd_target;
  logic        hbit_upd_taken;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] out_IW;
  logic [15:0] out_pc;
  logic        out_valid;
  logic        out_BPR;

  int compared;
  int mismatched;

  if_stage_hbit dut (
    .clk(clk), .resetn(resetn), .stall_IF(stall_IF),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .hbit_upd_valid(hbit_upd_valid), .hbit_upd_pc(hbit_upd_pc),
    .hbit_upd_target(hbit_upd_target), .hbit_upd_taken(hbit_upd_taken),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .out_IW(out_IW), .out_pc(out_pc), .out_valid(out_valid), .out_BPR(out_BPR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents are a fixed function of the address.
  assign imem_data = imem_addr ^ 16'h5a5a;

  // Reference model
  typedef struct { bit v; int tag; bit h; int tgt; } entry_t;
  entry_t tbl[8];
  int     m_pc;
  bit     m_started;

  logic [15:0] e_pc, e_iw;
  logic        e_valid, e_bpr;

  function automatic bit model_pred();
    entry_t e;
    e = tbl[m_pc % 8];
    return e.v && (e.tag == m_pc / 8) && e.h;
  endfunction

  task automatic model_expect();
    e_valid = resetn && m_started && !redirect_valid;
    e_pc    = resetn ? 16'(m_pc) : 16'h0000;
    e_iw    = e_valid ? (16'(m_pc) ^ 16'h5a5a) : 16'hfffe;
    e_bpr   = e_valid && model_pred();
  endtask

  task automatic model_clock();
    bit pt;
    if (!resetn) begin
      m_pc = 0;
      m_started = 1'b0;
      for (int i = 0; i < 8; i++) tbl[i] = '{1'b0, 0, 1'b0, 0};
    end else begin
      pt = model_pred();
      if (redirect_valid)   m_pc = int'(redirect_pc);
      else if (stall_IF)    m_pc = m_pc;
      else if (pt)          m_pc = tbl[m_pc % 8].tgt;
      else                  m_pc = (m_pc + 1) % 65536;
      if (hbit_upd_valid)
        tbl[int'(hbit_upd_pc) % 8] = '{1'b1, int'(hbit_upd_pc) / 8, hbit_upd_taken, int'(hbit_upd_target)};
      m_started = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_inputs();
    stall_IF = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    hbit_upd_valid = 1'b0; hbit_upd_pc = 16'h0000;
    hbit_upd_target = 16'h0000; hbit_upd_taken = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      #1;
      compared += 4;
      if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      if (out_BPR !== 1'b0) begin mismatched++; $display("FAIL reset_bpr got %b exp 0", out_BPR); end
      if (out_IW !== 16'hfffe) begin mismatched++; $display("FAIL reset_iw got %h exp fffe", out_IW); end
      if (out_pc !== 16'h0000) begin mismatched++; $display("FAIL reset_pc got %h exp 0000", out_pc); end
      tick();
    end
  endtask

  task automatic test_free_run();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      compared += 3;
      if (imem_addr !== 16'(i)) begin mismatched++; $display("FAIL free_addr got %h exp %h", imem_addr, 16'(i)); end
      if (out_valid !== (i != 0)) begin mismatched++; $display("FAIL free_valid got %b exp %b", out_valid, (i != 0)); end
      if (out_BPR !== 1'b0) begin mismatched++; $display("FAIL free_bpr got %b exp 0", out_BPR); end
      tick();
    end
  endtask

  task automatic test_predict();
    // At PC 4: train pc 5 taken to 0x40
    hbit_upd_valid = 1'b1; hbit_upd_pc = 16'h0005; hbit_upd_target = 16'h0040; hbit_upd_taken = 1'b1;
    tick();
    idle_inputs();
    #1;
    compared += 2;
    if (out_pc !== 16'h0005) begin mismatched++; $display("FAIL pred_pc got %h exp 0005", out_pc); end
    if (out_BPR !== 1'b1) begin mismatched++; $display("FAIL pred_bpr got %b exp 1", out_BPR); end
    tick();
    #1;
    compared++;
    if (out_pc !== 16'h0040) begin mismatched++; $display("FAIL pred_target got %h exp 0040", out_pc); end
    // Alias: 0x000d shares index 5 with a different tag
    redirect_valid = 1'b1; redirect_pc = 16'h000d;
    tick();
    idle_inputs();
    #1;
    compared++;
    if (out_BPR !== 1'b0) begin mismatched++; $display("FAIL alias_bpr got %b exp 0", out_BPR); end
    tick();
    #1;
    compared++;
    if (out_pc !== 16'h000e) begin mismatched++; $display("FAIL alias_next got %h exp 000e", out_pc); end
    // Retrain pc 5 not-taken, then revisit
    hbit_upd_valid = 1'b1; hbit_upd_pc = 16'h0005; hbit_upd_target = 16'h0040; hbit_upd_taken = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'h0005;
    tick();
    idle_inputs();
    #1;
    compared += 2;
    if (out_pc !== 16'h0005) begin mismatched++; $display("FAIL nt_pc got %h exp 0005", out_pc); end
    if (out_BPR !== 1'b0) begin mismatched++; $display("FAIL nt_bpr got %b exp 0", out_BPR); end
    tick();
    #1;
    compared++;
    if (out_pc !== 16'h0006) begin mismatched++; $display("FAIL nt_next got %h exp 0006", out_pc); end
  endtask

  task automatic test_stall_redirect();
    redirect_valid = 1'b1; redirect_pc = 16'h0008;
    tick();
    idle_inputs();
    stall_IF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      compared++;
      if (out_pc !== 16'h0008) begin mismatched++; $display("FAIL stall_pc cycle %0d got %h exp 0008", i, out_pc); end
      tick();
    end
    #1;
    compared++;
    if (out_pc !== 16'h0008) begin mismatched++; $display("FAIL stall_hold got %h exp 0008", out_pc); end
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    #1;
    compared += 2;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL redir_valid got %b exp 0", out_valid); end
    if (out_IW !== 16'hfffe) begin mismatched++; $display("FAIL redir_iw got %h exp fffe", out_IW); end
    tick();
    idle_inputs();
    #1;
    compared += 2;
    if (out_pc !== 16'h0100) begin mismatched++; $display("FAIL redir_pc got %h exp 0100", out_pc); end
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL redir_after_valid got %b exp 1", out_valid); end
    tick();
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 16'hffff;
    tick();
    idle_inputs();
    #1;
    compared++;
    if (out_pc !== 16'hffff) begin mismatched++; $display("FAIL wrap_pc got %h exp ffff", out_pc); end
    tick();
    #1;
    compared++;
    if (out_pc !== 16'h0000) begin mismatched++; $display("FAIL wrap_next got %h exp 0000", out_pc); end
  endtask

  task automatic test_same_cycle_update();
    // Train pc 2 taken to 0x30 while redirecting to 1
    redirect_valid = 1'b1; redirect_pc = 16'h0001;
    hbit_upd_valid = 1'b1; hbit_upd_pc = 16'h0002; hbit_upd_target = 16'h0030; hbit_upd_taken = 1'b1;
    tick();
    idle_inputs();
    tick();
    // PC 2, stalled, overwrite its own entry with not-taken
    stall_IF = 1'b1;
    hbit_upd_valid = 1'b1; hbit_upd_pc = 16'h0002; hbit_upd_target = 16'h0077; hbit_upd_taken = 1'b0;
    #1;
    compared += 2;
    if (out_pc !== 16'h0002) begin mismatched++; $display("FAIL same_pc got %h exp 0002", out_pc); end
    if (out_BPR !== 1'b1) begin mismatched++; $display("FAIL same_old_bpr got %b exp 1", out_BPR); end
    tick();
    hbit_upd_valid = 1'b0;
    #1;
    compared++;
    if (out_BPR !== 1'b0) begin mismatched++; $display("FAIL same_new_bpr got %b exp 0", out_BPR); end
    stall_IF = 1'b0;
    tick();
    #1;
    compared++;
    if (out_pc !== 16'h0003) begin mismatched++; $display("FAIL same_next got %h exp 0003", out_pc); end
  endtask

  task automatic test_reset_midstream();
    resetn = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    hbit_upd_valid = 1'b1; hbit_upd_pc = 16'h0000; hbit_upd_target = 16'h0055; hbit_upd_taken = 1'b1;
    tick();
    idle_inputs();
    resetn = 1'b1;
    #1;
    compared += 2;
    if (out_pc !== 16'h0000) begin mismatched++; $display("FAIL mid_pc got %h exp 0000", out_pc); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    tick();
    #1;
    compared++;
    if (out_pc !== 16'h0001) begin mismatched++; $display("FAIL mid_next got %h exp 0001", out_pc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      resetn          = ($urandom_range(0, 49) != 0);
      stall_IF        = ($urandom_range(0, 5) == 0);
      redirect_valid  = ($urandom_range(0, 7) == 0);
      redirect_pc     = 16'($urandom_range(0, 63));
      hbit_upd_valid  = ($urandom_range(0, 2) == 0);
      hbit_upd_pc     = 16'($urandom_range(0, 31));
      hbit_upd_target = 16'($urandom_range(0, 63));
      hbit_upd_taken  = 1'($urandom);
      #1;
      model_expect();
      compared += 4;
      if (out_pc !== e_pc) begin mismatched++; $display("FAIL rnd_pc c%0d got %h exp %h", c, out_pc, e_pc); end
      if (out_valid !== e_valid) begin mismatched++; $display("FAIL rnd_valid c%0d got %b exp %b", c, out_valid, e_valid); end
      if (out_IW !== e_iw) begin mismatched++; $display("FAIL rnd_iw c%0d got %h exp %h", c, out_IW, e_iw); end
      if (out_BPR !== e_bpr) begin mismatched++; $display("FAIL rnd_bpr c%0d got %b exp %b", c, out_BPR, e_bpr); end
      if (resetn) begin
        compared++;
        if (imem_addr !== 16'(m_pc)) begin mismatched++; $display("FAIL rnd_addr c%0d got %h exp %h", c, imem_addr, 16'(m_pc)); end
      end
      tick();
    end
    idle_inputs();
    resetn = 1'b1;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    m_pc = 0;
    m_started = 1'b0;
    for (int i = 0; i < 8; i++) tbl[i] = '{1'b0, 0, 1'b0, 0};
    test_reset();
    test_free_run();
    test_predict();
    test_stall_redirect();
    test_wrap();
    test_same_cycle_update();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
